// File: rtl/pwm_ramp_gen.sv
// Multi-channel LED breathing generator: a prescaled ramp per channel drives a glitch-free PWM.
// Optional macro PHASE_OFFSET_EN staggers the reset duty of each channel into a chaser pattern.
module pwm_ramp_gen #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DIV      = 6250000,
  parameter int DIV_W    = 26
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [1:0]                mode,
  input  logic [WIDTH-1:0]          step,
  output logic                      tick,
  output logic [CHANNELS*WIDTH-1:0] duty_out,
  output logic [CHANNELS-1:0]       pwm_out
);

  typedef enum logic [1:0] {
    MODE_TRI      = 2'd0,
    MODE_SAW_UP   = 2'd1,
    MODE_SAW_DOWN = 2'd2,
    MODE_HOLD     = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}};
  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] cnt;
  logic [WIDTH-1:0] pwm_cnt;
  mode_e            mode_sel;

  assign mode_sel = mode_e'(mode);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (en) begin
      if (cnt == LAST) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + DIV_W'(1);
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

  // PWM timebase keeps running while the ramps are frozen so the LEDs stay lit.
  always_ff @(posedge clk) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + WIDTH'(1);
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
`ifdef PHASE_OFFSET_EN
    localparam logic [WIDTH-1:0] RST_DUTY = WIDTH'((i * (2 ** WIDTH)) / CHANNELS);
`else
    localparam logic [WIDTH-1:0] RST_DUTY = '0;
`endif

    logic [WIDTH-1:0] duty;
    logic [WIDTH-1:0] duty_nxt;
    logic [WIDTH-1:0] duty_lat;
    logic [WIDTH:0]   sum;
    logic             pwm_q;
    dir_e             dir;
    dir_e             dir_nxt;

    always_ff @(posedge clk) begin
      if (rst) begin
        duty <= RST_DUTY;
        dir  <= DIR_UP;
      end else if (tick) begin
        duty <= duty_nxt;
        dir  <= dir_nxt;
      end
    end

    assign sum = {1'b0, duty} + {1'b0, step};

    // A zero step must not flip dir even when sitting on a limit.
    always_comb begin
      duty_nxt = duty;
      dir_nxt  = dir;
      if (step != '0) begin
        case (mode_sel)
          MODE_TRI: begin
            if (dir == DIR_UP) begin
              if (sum >= {1'b0, MAX}) begin
                duty_nxt = MAX;
                dir_nxt  = DIR_DOWN;
              end else begin
                duty_nxt = sum[WIDTH-1:0];
              end
            end else begin
              if (duty <= step) begin
                duty_nxt = '0;
                dir_nxt  = DIR_UP;
              end else begin
                duty_nxt = duty - step;
              end
            end
          end
          MODE_SAW_UP:   duty_nxt = (sum > {1'b0, MAX}) ? '0 : sum[WIDTH-1:0];
          MODE_SAW_DOWN: duty_nxt = (duty < step) ? MAX : duty - step;
          default:       duty_nxt = duty;
        endcase
      end
    end

    // Latching only at the end of a PWM period keeps each period's pulse width consistent.
    always_ff @(posedge clk) begin
      if (rst) begin
        duty_lat <= '0;
        pwm_q    <= 1'b0;
      end else begin
        if (pwm_cnt == MAX) duty_lat <= duty;
        pwm_q <= (pwm_cnt < duty_lat);
      end
    end

    assign duty_out[i*WIDTH +: WIDTH] = duty;
    assign pwm_out[i]                 = pwm_q;
  end

endmodule
